gsplat_tile_writer: RTL

Framebuffer write-back stage of the GSplat rasterizer. Takes one finished 16x16 tile from the rasterizer's on-chip tile colour buffer, packs pairs of 32bpp pixels into 64-bit words, and writes it to the DDR3 framebuffer at 0x30000000. The framebuffer is 640x480 with a stride of 2560 B. Output goes as one 8-beat Avalon burst per tile row on the DDRAM port. It sits directly downstream of the tile rasterizer inside `gsplat_top`.

---
 rtl/gsplat_tile_writer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/gsplat_tile_writer.sv
// gsplat_tile_writer: copies one 16x16 tile from the tile colour buffer to the DDR3 framebuffer,
// one 8-beat 64-bit Avalon burst per tile row.
module gsplat_tile_writer #(
    parameter logic [28:0] FB_BASE_WORD = 29'h0600_0000,
    parameter int          STRIDE_WORDS = 320,
    parameter int          TILES_X      = 40,
    parameter int          TILES_Y      = 30
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  tile_x,
    input  logic [4:0]  tile_y,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  tb_addr,
    input  logic [31:0] tb_data,
    input  logic        ddram_busy,
    output logic [7:0]  ddram_burstcnt,
    output logic [28:0] ddram_addr,
    output logic [63:0] ddram_din,
    output logic [7:0]  ddram_be,
    output logic        ddram_we
);
    typedef enum logic [1:0] {IDLE, FETCH, BURST, FIN} state_t;

    state_t      state;
    logic [4:0]  f;
    logic [3:0]  row;
    logic [2:0]  k;
    logic [5:0]  tx;
    logic [4:0]  ty;
    logic [63:0] rbuf [8];
    logic [3:0]  cap;
    logic [8:0]  line;
    logic [17:0] prod;
    logic [28:0] burst_addr;
    logic        in_range;

    assign ddram_burstcnt = 8'd8;
    assign ddram_be       = 8'hFF;
    assign in_range       = (7'(tile_x) < 7'(TILES_X)) && (6'(tile_y) < 6'(TILES_Y));
    // tile buffer data lags the address by one cycle, so column f-1 arrives while f is issued
    assign cap            = f[3:0] - 4'd1;
    assign line           = {ty, row};
    assign prod           = 18'(line) * 18'(STRIDE_WORDS);
    assign burst_addr     = FB_BASE_WORD + {11'd0, prod} + {20'd0, tx, 3'd0};

    always_ff @(posedge clk) begin
        if (state == FETCH && f != 5'd0) begin
            if (cap[0]) rbuf[cap[3:1]][63:32] <= tb_data;
            else        rbuf[cap[3:1]][31:0]  <= tb_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            f          <= 5'd0;
            row        <= 4'd0;
            k          <= 3'd0;
            tx         <= 6'd0;
            ty         <= 5'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            tb_addr    <= 8'd0;
            ddram_addr <= 29'd0;
            ddram_din  <= 64'd0;
            ddram_we   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && in_range) begin
                        tx      <= tile_x;
                        ty      <= tile_y;
                        row     <= 4'd0;
                        f       <= 5'd0;
                        tb_addr <= 8'd0;
                        busy    <= 1'b1;
                        state   <= FETCH;
                    end else if (start) begin
                        err   <= 1'b1;
                        busy  <= 1'b1;
                        state <= FIN;
                    end
                end
                FETCH: begin
                    f       <= f + 5'd1;
                    tb_addr <= {row, f[3:0] + 4'd1};
                    if (f == 5'd16) begin
                        k          <= 3'd0;
                        ddram_we   <= 1'b1;
                        ddram_din  <= rbuf[0];
                        ddram_addr <= burst_addr;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (!ddram_busy) begin
                        k         <= k + 3'd1;
                        ddram_din <= rbuf[k + 3'd1];
                        if (k == 3'd7) begin
                            ddram_we <= 1'b0;
                            if (row == 4'd15) begin
                                done  <= 1'b1;
                                state <= FIN;
                            end else begin
                                row     <= row + 4'd1;
                                f       <= 5'd0;
                                tb_addr <= {row + 4'd1, 4'd0};
                                state   <= FETCH;
                            end
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
